// File: rtl/lo_sweep_sequencer.sv
// lo_sweep_sequencer: steps the internal LO divider setting from a latched start to stop value, settling then dwelling at each step.
module lo_sweep_sequencer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_ext_req,
  input  logic [2:0] i_start_sel,
  input  logic [2:0] i_stop_sel,
  input  logic [3:0] i_dwell_cfg,
  output logic       o_ext_lo_en,
  output logic [2:0] o_int_lo_settings,
  output logic       o_lo_valid,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt;
  logic [2:0] r_set, w_set, r_stop, w_stop;
  logic [3:0] r_dwell, w_dwell;
  logic       r_ext, w_go;
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt + 8'd1;
    w_set   = r_set;
    w_stop  = r_stop;
    w_dwell = r_dwell;
    w_go    = r_state == IDLE && i_start && !i_ext_req && !i_abort;
    case (r_state)
      IDLE: begin
        w_cnt = 8'd0;
        if (w_go) begin
          w_next  = SETTLE;
          w_set   = i_start_sel;
          w_stop  = i_stop_sel;
          w_dwell = i_dwell_cfg;
        end
      end
      SETTLE: if (r_cnt == 8'd7) begin
        w_next = DWELL;
        w_cnt  = 8'd0;
      end
      DWELL: if (r_cnt == {r_dwell, 4'hF}) begin
        w_cnt  = 8'd0;
        w_next = r_set == r_stop ? DONE : SETTLE;
        w_set  = r_set == r_stop ? r_set : r_set + 3'd1;
      end
      DONE: begin
        w_next = IDLE;
        w_cnt  = 8'd0;
      end
    endcase
    // abort discards any pending step increment so the current setting holds
    if (i_abort) begin
      w_next = IDLE;
      w_cnt  = 8'd0;
      w_set  = r_set;
    end
  end
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_set   <= 3'd0;
      r_stop  <= 3'd0;
      r_dwell <= 4'd0;
      r_ext   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_set   <= w_set;
      r_stop  <= w_stop;
      r_dwell <= w_dwell;
      r_ext   <= w_next == IDLE && i_ext_req;
    end
  end
  assign o_ext_lo_en       = r_ext;
  assign o_int_lo_settings = r_set;
  assign o_lo_valid        = r_state == DWELL;
  assign o_busy            = r_state == SETTLE || r_state == DWELL;
  assign o_done            = r_state == DONE;
endmodule

// File: tb/tb_lo_sweep_sequencer.sv
// tb_lo_sweep_sequencer: table-driven and randomized sweeps checked cycle by cycle against an expected output trace.
module tb_lo_sweep_sequencer;
  logic       clk = 0, n_rst = 1, start = 0, abort = 0, ext_req = 0;
  logic [2:0] ssel = 0, esel = 0;
  logic [3:0] dcfg = 0;
  logic       ext_lo_en, lo_valid, busy, done;
  logic [2:0] lo_set;
  logic [6:0] w_out;
  int checks = 0, errors = 0;
  typedef struct {logic [2:0] s; logic [2:0] e; logic [3:0] d; int busy_n;} vec_t;
  vec_t tbl[6];

  lo_sweep_sequencer dut (
    .clk(clk), .n_rst(n_rst), .i_start(start), .i_abort(abort), .i_ext_req(ext_req),
    .i_start_sel(ssel), .i_stop_sel(esel), .i_dwell_cfg(dcfg),
    .o_ext_lo_en(ext_lo_en), .o_int_lo_settings(lo_set), .o_lo_valid(lo_valid),
    .o_busy(busy), .o_done(done)
  );

  assign w_out = {ext_lo_en, lo_set, lo_valid, busy, done};
  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic start_pulse(input logic [2:0] s, input logic [2:0] e, input logic [3:0] d);
    @(negedge clk);
    ssel = s; esel = e; dcfg = d; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Expected trace: per step 8 settle cycles then (d+1)*16 valid cycles, then one done cycle, then idle.
  task automatic run_sweep(input logic [2:0] s, input logic [2:0] e, input logic [3:0] d, output int busy_n);
    logic [6:0] q[$];
    logic [2:0] st;
    int n, dw;
    n  = ((int'(e) - int'(s) + 8) % 8) + 1;
    dw = (int'(d) + 1) * 16;
    for (int k = 0; k < n; k++) begin
      st = 3'((int'(s) + k) % 8);
      for (int j = 0; j < 8 + dw; j++) q.push_back({1'b0, st, j >= 8, 1'b1, 1'b0});
    end
    q.push_back({1'b0, e, 3'b001});
    q.push_back({1'b0, e, 3'b000});
    start_pulse(s, e, d);
    busy_n = 0;
    foreach (q[i]) begin
      chk("sweep_trace", w_out, q[i]);
      busy_n += int'(busy);
      if (i < q.size() - 2) begin
        start = 1'($urandom_range(0, 1)); ext_req = 1'($urandom_range(0, 1));
        ssel = 3'($urandom); esel = 3'($urandom); dcfg = 4'($urandom);
      end else begin
        start = 0; ext_req = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int bn;
    tbl[0] = '{3'd2, 3'd4, 4'd0, 72};
    tbl[1] = '{3'd6, 3'd1, 4'd15, 1056};
    tbl[2] = '{3'd3, 3'd3, 4'd1, 40};
    tbl[3] = '{3'd0, 3'd1, 4'd0, 48};
    tbl[4] = '{3'd7, 3'd0, 4'd2, 112};
    tbl[5] = '{3'd5, 3'd4, 4'd0, 192};
    #10;
    chk("reset_state", w_out, 7'd0);
    @(negedge clk); n_rst = 0;
    @(negedge clk);
    chk("idle_after_reset", w_out, 7'd0);
    foreach (tbl[i]) begin
      run_sweep(tbl[i].s, tbl[i].e, tbl[i].d, bn);
      chk("busy_cycles", 7'(bn), 7'(tbl[i].busy_n));
    end
    for (int r = 0; r < 10; r++) begin
      run_sweep(3'($urandom), 3'($urandom), 4'($urandom_range(0, 5)), bn);
    end
    // abort during cycle 5 of the second dwell
    start_pulse(3'd2, 3'd4, 4'd0);
    repeat (36) @(negedge clk);
    chk("pre_abort", w_out, {1'b0, 3'd3, 3'b110});
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort", w_out, {1'b0, 3'd3, 3'b000});
    bn = 0;
    repeat (100) begin @(negedge clk); bn += int'(busy) + int'(done); end
    chk("no_done_after_abort", 7'(bn), 7'd0);
    // abort and start together
    @(negedge clk); start = 1; abort = 1; ssel = 3'd5;
    @(negedge clk); start = 0; abort = 0;
    chk("abort_beats_start", w_out, {1'b0, 3'd3, 3'b000});
    // external LO request blocks start
    ext_req = 1;
    @(negedge clk);
    chk("ext_lo_latency", w_out, {1'b1, 3'd3, 3'b000});
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_blocked_by_ext", w_out, {1'b1, 3'd3, 3'b000});
    ext_req = 0;
    @(negedge clk);
    chk("ext_lo_drop", w_out, {1'b0, 3'd3, 3'b000});
    run_sweep(3'd1, 3'd2, 4'd0, bn);
    chk("busy_after_ext", 7'(bn), 7'd48);
    // async reset mid-settle
    start_pulse(3'd2, 3'd4, 4'd0);
    repeat (3) @(negedge clk);
    #5 n_rst = 1;
    #1 chk("async_reset", w_out, 7'd0);
    @(negedge clk); n_rst = 0;
    bn = 0;
    repeat (20) begin @(negedge clk); bn += int'(done) + int'(busy); end
    chk("no_done_after_reset", 7'(bn), 7'd0);
    run_sweep(3'd2, 3'd4, 4'd0, bn);
    chk("busy_after_reset", 7'(bn), 7'd72);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
